// File: rtl/int_req_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_req_ctrl_pkg
// Shared definitions for the interrupt request controller and the CP0 side:
//   - FSM state encoding (IDLE/REQ/GAP)
//   - interrupt code meaning "no request"
//   - CP0 register index constants shared with the CP0 register file
//   - msb_index(): index of the highest set bit of a 4-bit vector
// Optional build macro used by this block: INT_SYNC_EN (see int_edge_capture).
// -----------------------------------------------------------------------------
package int_req_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [1:0] INT_CODE_NONE = 2'd0;

    // CP0 register indices
    localparam int unsigned CP0_REG_IE  = 32'd0;
    localparam int unsigned CP0_REG_INM = 32'd1;
    localparam int unsigned CP0_REG_EPC = 32'd2;

    // Highest set bit of v; returns 0 when v is zero, so callers must
    // qualify the result with |v.
    function automatic logic [1:0] msb_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_req_ctrl_edge.sv
// -----------------------------------------------------------------------------
// int_edge_capture
// Rising-edge capture for the external interrupt lines.
//   in_CLK      : system clock, rising edge
//   in_RST      : asynchronous active-high reset
//   in_irq      : raw interrupt lines
//   in_clr      : per-source clear of the pending bit (service accepted)
//   out_pending : latched, not-yet-serviced edges (registered)
// Build macro INT_SYNC_EN: when defined, each line passes a 2-flop
// synchronizer before edge detection (adds 2 cycles of latency). When
// undefined, in_irq must already be synchronous to in_CLK.
// -----------------------------------------------------------------------------
module int_edge_capture #(
    parameter int N_SRC = 3
) (
    input  logic             in_CLK,
    input  logic             in_RST,
    input  logic [N_SRC-1:0] in_irq,
    input  logic [N_SRC-1:0] in_clr,
    output logic [N_SRC-1:0] out_pending
);

    logic [N_SRC-1:0] irq_s;
    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] last_q;
    logic [N_SRC-1:0] last_d;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;

`ifdef INT_SYNC_EN
    logic [N_SRC-1:0] sync1_q;
    logic [N_SRC-1:0] sync1_d;
    logic [N_SRC-1:0] sync2_q;
    logic [N_SRC-1:0] sync2_d;

    // Synchronizer next-state: shift the raw lines through two stages.
    always_comb begin
        sync1_d = in_irq;
        sync2_d = sync1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            sync1_q <= {N_SRC{1'b0}};
            sync2_q <= {N_SRC{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = in_irq;
`endif

    // Edge detect and pending update; a same-cycle set beats the clear so a
    // new edge arriving as the old one is accepted is not lost.
    always_comb begin
        last_d    = irq_s;
        rise_s    = irq_s & ~last_q;
        pending_d = (pending_q & ~in_clr) | rise_s;
    end

    // Edge history and pending flops.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            last_q    <= {N_SRC{1'b0}};
            pending_q <= {N_SRC{1'b0}};
        end else begin
            last_q    <= last_d;
            pending_q <= pending_d;
        end
    end

    assign out_pending = pending_q;

endmodule

// File: rtl/int_req_ctrl.sv
// -----------------------------------------------------------------------------
// int_req_ctrl
// Initiator side of the CP0 interrupt interface: captures interrupt edges,
// applies mask/global enable, selects one source by fixed priority (higher
// index wins), issues a registered request code and tracks nested in-service
// levels until eret.
//   in_CLK        : system clock, rising edge
//   in_RST        : asynchronous active-high reset
//   in_IRQ        : raw interrupt lines (rising-edge triggered), source i -> code i+1
//   in_IE         : global interrupt enable from CP0
//   in_INM        : CP0 mask, bit i=1 masks source i (bits >= N_SRC ignored)
//   in_ack        : pipeline accepted the current request
//   in_eret       : handler of the top in-service level returned (pulse)
//   out_req       : request valid (registered)
//   out_code      : requesting source code, 0 when out_req=0 (registered)
//   out_pending   : latched, not-yet-serviced edges
//   out_inservice : levels currently being serviced
// Build macro INT_SYNC_EN: enables input synchronizers in int_edge_capture.
// -----------------------------------------------------------------------------
module int_req_ctrl
    import int_req_ctrl_pkg::*;
#(
    parameter int N_SRC  = 3,
    parameter int CODE_W = 2
) (
    input  logic              in_CLK,
    input  logic              in_RST,
    input  logic [N_SRC-1:0]  in_IRQ,
    input  logic              in_IE,
    input  logic [3:0]        in_INM,
    input  logic              in_ack,
    input  logic              in_eret,
    output logic              out_req,
    output logic [CODE_W-1:0] out_code,
    output logic [N_SRC-1:0]  out_pending,
    output logic [N_SRC-1:0]  out_inservice
);

    localparam int PAD_W = 4 - N_SRC;

    state_e            state_q;
    state_e            state_d;
    logic              req_q;
    logic              req_d;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_d;
    logic [1:0]        sel_q;
    logic [1:0]        sel_d;
    logic [N_SRC-1:0]  inservice_q;
    logic [N_SRC-1:0]  inservice_d;

    logic [N_SRC-1:0]  pending_s;
    logic [N_SRC-1:0]  elig_s;
    logic [N_SRC-1:0]  clr_s;
    logic [N_SRC-1:0]  eret_clr_s;
    logic [1:0]        is_top_s;
    logic [1:0]        elig_top_s;
    logic              elig_any_s;
    logic              ack_take_s;
    logic              unused_inm_s;

    // Mask bits above the implemented sources are deliberately ignored.
    assign unused_inm_s = ^in_INM;

    int_edge_capture #(
        .N_SRC (N_SRC)
    ) u_edge (
        .in_CLK      (in_CLK),
        .in_RST      (in_RST),
        .in_irq      (in_IRQ),
        .in_clr      (clr_s),
        .out_pending (pending_s)
    );

    // Eligibility and priority select. A source may only preempt when it is
    // strictly above the highest level already in service.
    always_comb begin
        is_top_s = msb_index({{PAD_W{1'b0}}, inservice_q});
        elig_s   = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            elig_s[i] = pending_s[i] & ~in_INM[i] & in_IE &
                        ((inservice_q == {N_SRC{1'b0}}) || (i > int'(is_top_s)));
        end
        elig_any_s = |elig_s;
        elig_top_s = msb_index({{PAD_W{1'b0}}, elig_s});
    end

    // Ack bookkeeping: which pending bit to clear and which levels change.
    // The ack set is OR-ed in after the eret clear so a level accepted in the
    // same cycle as an eret stays in service.
    always_comb begin
        ack_take_s = (state_q == REQ) & in_ack;
        clr_s      = {N_SRC{1'b0}};
        eret_clr_s = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            clr_s[i]      = ack_take_s & (sel_q == 2'(i));
            eret_clr_s[i] = in_eret & (inservice_q != {N_SRC{1'b0}}) & (is_top_s == 2'(i));
        end
        inservice_d = (inservice_q & ~eret_clr_s) | clr_s;
    end

    // FSM next-state and registered output values.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        code_d  = code_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (elig_any_s) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    code_d  = elig_top_s + 2'd1;
                    sel_d   = elig_top_s;
                end else begin
                    req_d   = 1'b0;
                    code_d  = INT_CODE_NONE;
                end
            end
            REQ: begin
                // Ack takes the request; losing IE first withdraws it with
                // pending retained. Both leave through GAP so the next
                // request produces a fresh rising edge on the code.
                if (in_ack || !in_IE) begin
                    state_d = GAP;
                    req_d   = 1'b0;
                    code_d  = INT_CODE_NONE;
                end else begin
                    state_d = REQ;
                end
            end
            GAP: begin
                state_d = IDLE;
                req_d   = 1'b0;
                code_d  = INT_CODE_NONE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                code_d  = INT_CODE_NONE;
                sel_d   = 2'd0;
            end
        endcase
    end

    // FSM state and registered request outputs.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            code_q  <= INT_CODE_NONE;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            code_q  <= code_d;
            sel_q   <= sel_d;
        end
    end

    // In-service level register.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            inservice_q <= {N_SRC{1'b0}};
        end else begin
            inservice_q <= inservice_d;
        end
    end

    assign out_req       = req_q;
    assign out_code      = code_q;
    assign out_pending   = pending_s;
    assign out_inservice = inservice_q;

endmodule

// File: tb/tb_int_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_req_ctrl
// Randomized bench for int_req_ctrl with a behavioural reference model:
// pending edges as a bit set, in-service levels as a stack (nesting only ever
// pushes a higher level), and the request as an active flag plus a quiet
// countdown between requests.
// -----------------------------------------------------------------------------
module tb_int_req_ctrl;

    localparam int NS = 3;
`ifdef INT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          in_CLK = 1'b0;
    logic          in_RST = 1'b1;
    logic [NS-1:0] in_IRQ = '0;
    logic          in_IE = 1'b0;
    logic [3:0]    in_INM = '0;
    logic          in_ack = 1'b0;
    logic          in_eret = 1'b0;
    logic          out_req;
    logic [1:0]    out_code;
    logic [NS-1:0] out_pending;
    logic [NS-1:0] out_inservice;

    int n_vec = 0;
    int n_err = 0;

    int_req_ctrl #(.N_SRC(NS), .CODE_W(2)) dut (
        .in_CLK        (in_CLK),
        .in_RST        (in_RST),
        .in_IRQ        (in_IRQ),
        .in_IE         (in_IE),
        .in_INM        (in_INM),
        .in_ack        (in_ack),
        .in_eret       (in_eret),
        .out_req       (out_req),
        .out_code      (out_code),
        .out_pending   (out_pending),
        .out_inservice (out_inservice)
    );

    always #5 in_CLK = ~in_CLK;

    // ---------------- reference model ----------------
    bit [NS-1:0] m_pend, m_last, m_s1, m_s2;
    int          m_stack[$];
    bit          m_req;
    int          m_sel;
    int          m_cool;

    function automatic void model_reset();
        m_pend = '0; m_last = '0; m_s1 = '0; m_s2 = '0;
        m_stack.delete();
        m_req = 1'b0; m_sel = 0; m_cool = 0;
    endfunction

    // One rising clock edge, using the inputs held across it.
    function automatic void model_update();
        bit [NS-1:0] seen, edges, clr;
        int top, pick;
`ifdef INT_SYNC_EN
        seen = m_s2; m_s2 = m_s1; m_s1 = in_IRQ;
`else
        seen = in_IRQ;
`endif
        edges  = seen & ~m_last;
        m_last = seen;
        top  = (m_stack.size() > 0) ? m_stack[$] : -1;
        pick = -1;
        for (int i = 0; i < NS; i++)
            if (m_pend[i] && !in_INM[i] && in_IE && i > top) pick = i;
        clr = '0;
        if (m_req && in_ack) clr[m_sel] = 1'b1;
        if (in_eret && m_stack.size() > 0) void'(m_stack.pop_back());
        if (m_req && in_ack) m_stack.push_back(m_sel);
        m_pend = (m_pend & ~clr) | edges;
        if (m_req) begin
            if (in_ack || !in_IE) begin m_req = 1'b0; m_cool = 1; end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (pick >= 0) begin
            m_req = 1'b1; m_sel = pick;
        end
    endfunction

    function automatic bit [NS-1:0] model_inservice();
        bit [NS-1:0] v = '0;
        foreach (m_stack[k]) v[m_stack[k]] = 1'b1;
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("req", 32'(out_req), 32'(m_req));
        check_eq("code", 32'(out_code), m_req ? 32'(m_sel + 1) : 32'd0);
        check_eq("pending", 32'(out_pending), 32'(m_pend));
        check_eq("inservice", 32'(out_inservice), 32'(model_inservice()));
    endtask

    // Advance one cycle: model follows the edge, outputs compared mid-low phase.
    task automatic step();
        @(posedge in_CLK);
        model_update();
        @(negedge in_CLK);
        compare_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge in_CLK);
        check_eq("rst_req", 32'(out_req), 32'd0);
        check_eq("rst_code", 32'(out_code), 32'd0);
        check_eq("rst_pending", 32'(out_pending), 32'd0);
        check_eq("rst_inservice", 32'(out_inservice), 32'd0);
        in_RST = 1'b0;
        in_IE  = 1'b1;
        step();

        // Basic: pulse IRQ[0], request 2 cycles later, ack moves it to service.
        in_IRQ = 3'b001; step();
        in_IRQ = 3'b000; repeat (SYNC_LAT) step();
        step();
        check_eq("basic_code", 32'(out_code), 32'd1);
        in_ack = 1'b1; step(); in_ack = 1'b0;
        check_eq("basic_ack_code", 32'(out_code), 32'd0);
        check_eq("basic_ack_insvc", 32'(out_inservice), 32'b001);
        in_eret = 1'b1; step(); in_eret = 1'b0;
        step();

        // Priority: IRQ[0] and IRQ[2] together, 3 first, 1 blocked until eret.
        in_IRQ = 3'b101; step();
        in_IRQ = 3'b000; repeat (SYNC_LAT) step();
        step();
        check_eq("prio_code_hi", 32'(out_code), 32'd3);
        in_ack = 1'b1; step(); in_ack = 1'b0;
        step(); step();
        check_eq("prio_blocked", 32'(out_req), 32'd0);
        in_eret = 1'b1; step(); in_eret = 1'b0;
        step();
        check_eq("prio_code_lo", 32'(out_code), 32'd1);
        in_ack = 1'b1; step(); in_ack = 1'b0;
        in_eret = 1'b1; step(); in_eret = 1'b0;
        step();

        // Masked source stays pending until the mask is lifted.
        in_INM = 4'b0010; in_IRQ = 3'b010; step();
        in_IRQ = 3'b000; repeat (SYNC_LAT + 3) step();
        check_eq("mask_noreq", 32'(out_req), 32'd0);
        in_INM = 4'b0000; step();
        check_eq("mask_code", 32'(out_code), 32'd2);
        // Withdraw: IE drops before ack.
        in_IE = 1'b0; step();
        check_eq("wd_code", 32'(out_code), 32'd0);
        check_eq("wd_pending", 32'(out_pending), 32'b010);
        in_IE = 1'b1; repeat (3) step();
        in_ack = 1'b1; step(); in_ack = 1'b0;
        in_eret = 1'b1; step(); in_eret = 1'b0;

        // Async reset in the middle of a request, away from the clock edge.
        in_IRQ = 3'b100; step();
        in_IRQ = 3'b000; repeat (SYNC_LAT) step();
        step();
        check_eq("mid_req", 32'(out_req), 32'd1);
        #2 in_RST = 1'b1;
        #1;
        check_eq("arst_req", 32'(out_req), 32'd0);
        check_eq("arst_code", 32'(out_code), 32'd0);
        check_eq("arst_pending", 32'(out_pending), 32'd0);
        check_eq("arst_insvc", 32'(out_inservice), 32'd0);
        model_reset();
        @(posedge in_CLK);
        @(negedge in_CLK);
        in_RST = 1'b0;
        repeat (6) step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            in_IRQ  = in_IRQ ^ (3'($urandom) & 3'($urandom));
            in_ack  = ($urandom_range(0, 3) == 0);
            in_eret = ($urandom_range(0, 7) == 0);
            in_IE   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0)
                in_INM = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/int_req_ctrl.md
Name: int_req_ctrl

Overview:
- Interrupt request controller: initiator side of the CP0 interrupt interface.
- Captures edges on external interrupt lines, applies the CP0 mask (INM) and global enable (IE), and selects one source by fixed priority.
- Drives the 2-bit interrupt code that CP0 samples to save EPC; tracks in-service levels for nesting until eret.
- Sits between the external interrupt pins and CP0/pipeline redirect logic.

Parameters:
- N_SRC, 3: number of interrupt sources; must be 1..3, since code 0 means "none".
- CODE_W, 2: width of out_code; fixed at 2.

Ports:
- in_CLK  input  1  system clock, rising edge.
- in_RST  input  1  asynchronous active-high reset.
- in_IRQ  input  N_SRC  raw interrupt lines, rising-edge triggered. Source i maps to code i+1; higher index = higher priority.
- in_IE  input  1  global interrupt enable from CP0.
- in_INM  input  4  mask from CP0. Bit i=1 masks source i; bits above N_SRC-1 are ignored.
- in_ack  input  1  pipeline accepted the redirect for the current request.
- in_eret  input  1  one-cycle pulse; handler for the top in-service level has returned.
- out_req  output  1  request valid.
- out_code  output  2  code of the requesting source; 0 when out_req=0.
- out_pending  output  N_SRC  latched, not-yet-serviced edges.
- out_inservice  output  N_SRC  levels currently being serviced.

Behaviour:
- Reset (async, in_RST=1): state=IDLE; out_req=0, out_code=0, out_pending=0, out_inservice=0; edge-detect history registers cleared. Reset mid-request aborts immediately; the pending edge is lost.
- Edge capture: pending[i] set on the cycle after in_IRQ[i] rises (last-sample 0, current 1).
  - A set and a clear of the same bit in the same cycle: set wins.
- Eligible(i) = pending[i] & ~in_INM[i] & in_IE & (i > highest set bit of inservice, or inservice==0).
- FSM states: IDLE, REQ, GAP.
  - IDLE: if any source is eligible, latch sel = highest eligible index. Next cycle: REQ, out_req=1, out_code=sel+1.
  - REQ: out_code held stable regardless of later edges or mask changes. On in_ack: pending[sel] cleared, inservice[sel] set, go to GAP.
  - REQ, if in_IE drops before ack: withdraw. out_req=0, out_code=0, pending retained, go to GAP.
  - GAP: exactly one cycle with out_code=0, so CP0's OR-of-code edge detector sees a fresh rising edge on the next request. Then IDLE.
- Latency: edge on in_IRQ to out_req=1 is 2 cycles in IDLE; 4 cycles with INT_SYNC_EN.
- in_eret: clear the highest set inservice bit. eret with inservice==0 is ignored.
  - eret in the same cycle as ack: the ack set is applied after the eret clear, so the new level stays in service.
- Nesting: a higher-priority edge during service is requested; equal or lower stays pending until eret.
- out_code and out_req are registered; no combinational path from inputs.

Optional Feature:
- Macro INT_SYNC_EN.
  - Defined: each in_IRQ bit passes a 2-flop synchronizer before edge detection. Adds 2 cycles of latency; all sync flops reset to 0.
  - Undefined: in_IRQ is sampled directly by the edge-detect register; inputs must already be synchronous to in_CLK.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, REQ=2'd1, GAP=2'd2;
  - INT_CODE_NONE=2'd0;
  - CP0 register index constants IE=0, INM=1, EPC=2, shared with the CP0 register file.
- One natural sub-module: int_edge_capture (optional synchronizer, edge detect, pending set/clear), instantiated once with N_SRC width.
- Priority select, in-service tracking and FSM stay in the top module.

Test Plan:
- Basic: IE=1, INM=0, pulse IRQ[0] -> out_req=1, out_code=1 two cycles later. in_ack -> out_code=0, inservice=3'b001, pending=0.
- Priority: IRQ[0] and IRQ[2] rise in the same cycle -> out_code=3 first. After ack and GAP, IRQ[0] is still pending but blocked until eret. After eret, out_code=1.
- Masking: INM=4'b0010, pulse IRQ[1] -> no request, pending=3'b010. Set INM=0 -> out_code=2 within 2 cycles.
- Withdraw: IE drops in REQ before ack -> out_code=0 next cycle, pending kept. IE=1 again -> request reissued with code 0 seen for at least one cycle.
- Nesting: service IRQ[0], then pulse IRQ[1] -> out_code=2, inservice=3'b011. eret -> 3'b001; eret -> 3'b000.
- Async reset asserted mid-REQ, off-clock-edge -> all outputs 0 immediately; after release, no spurious request.
